stream_err_lanes: RTL

- Parametrised successor to the single-lane error stage.
- Computes per-lane error = stage output − expected, across LANES parallel lanes of signed fixed-point data.
- Expected vectors are buffered in an internal FIFO of depth DEPTH, so the target stream can arrive ahead of the network output.
- Sits between the last network stage and the back-propagation input, with valid/ready/first-flag handshakes on every stream.

---
 rtl/stream_err_lanes.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/stream_err_lanes.sv
// Multi-lane error stage: error = data_out - expected per lane, saturated, with expected vectors buffered in a FIFO.
// Optional ERR_SUM_EN adds a per-frame sum of |error| reported on err_sum / err_sum_vld.
module stream_err_lanes #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int DEPTH  = 8,
  parameter int SUM_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES*DATA_W-1:0]   expected,
  input  logic                      expected_fst,
  input  logic                      expected_vld,
  output logic                      expected_rdy,
  input  logic [LANES*DATA_W-1:0]   data_out,
  input  logic                      data_out_fst,
  input  logic                      data_out_vld,
  output logic                      data_out_rdy,
  output logic [LANES*DATA_W-1:0]   error,
  output logic                      error_fst,
  output logic                      error_vld,
  input  logic                      error_rdy,
  output logic                      fst_mismatch
`ifdef ERR_SUM_EN
  ,
  output logic [SUM_W-1:0]          err_sum,
  output logic                      err_sum_vld
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int VW = LANES * DATA_W;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Signed difference at DATA_W+1 bits, clamped to the DATA_W range.
  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    if (d[DATA_W] != d[DATA_W-1]) begin
      if (d[DATA_W]) begin
        sat_sub = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        sat_sub = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end else begin
      sat_sub = d[DATA_W-1:0];
    end
  endfunction

  logic [VW-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] fst_mem_r;
  logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic             expected_rdy_r, full_nxt_s, not_empty_s, can_load_s;
  logic             push_s, join_s, head_fst_s;
  logic [VW-1:0]    head_s, diff_s;
  logic [VW-1:0]    error_r;
  logic             error_fst_r, error_vld_r, fst_mismatch_r;

  // Handshake join, pointer update and per-lane saturated difference.
  always_comb begin
    not_empty_s  = (wr_ptr_r != rd_ptr_r);
    can_load_s   = !error_vld_r || error_rdy;
    data_out_rdy = not_empty_s && can_load_s;
    join_s       = data_out_vld && data_out_rdy;
    push_s       = expected_vld && expected_rdy_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (join_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    full_nxt_s = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                 (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    head_s     = mem_r[rd_ptr_r[AW-1:0]];
    head_fst_s = fst_mem_r[rd_ptr_r[AW-1:0]];
    diff_s     = '0;
    for (int i = 0; i < LANES; i++) begin
      diff_s[i*DATA_W +: DATA_W] = sat_sub(data_out[i*DATA_W +: DATA_W],
                                           head_s[i*DATA_W +: DATA_W]);
    end
  end

  // FIFO storage; validity is defined by the pointers, so contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]]     <= expected;
      fst_mem_r[wr_ptr_r[AW-1:0]] <= expected_fst;
    end
  end

  // Pointers and the registered not-full flag that drives expected_rdy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      expected_rdy_r <= 1'b0;
    end else begin
      wr_ptr_r       <= wr_ptr_nxt_s;
      rd_ptr_r       <= rd_ptr_nxt_s;
      expected_rdy_r <= !full_nxt_s;
    end
  end

  // Output register and sticky frame-alignment flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_r        <= '0;
      error_fst_r    <= 1'b0;
      error_vld_r    <= 1'b0;
      fst_mismatch_r <= 1'b0;
    end else begin
      if (join_s) begin
        error_r     <= diff_s;
        error_fst_r <= data_out_fst;
        error_vld_r <= 1'b1;
        if (head_fst_s != data_out_fst) begin
          fst_mismatch_r <= 1'b1;
        end
      end else if (error_rdy) begin
        error_vld_r <= 1'b0;
      end
    end
  end

  assign expected_rdy = expected_rdy_r;
  assign error        = error_r;
  assign error_fst    = error_fst_r;
  assign error_vld    = error_vld_r;
  assign fst_mismatch = fst_mismatch_r;

`ifdef ERR_SUM_EN
  localparam int BSW = DATA_W + $clog2(LANES) + 1;
  localparam int XW  = ((SUM_W > BSW) ? SUM_W : BSW) + 1;
  localparam logic [XW-1:0] SUM_MAX = {{(XW-SUM_W){1'b0}}, {SUM_W{1'b1}}};
  localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};

  // Magnitude as unsigned; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1]) begin
      abs_val = ~v + ONE_D;
    end else begin
      abs_val = v;
    end
  endfunction

  logic [SUM_W-1:0] acc_r, err_sum_r, acc_nxt_s;
  logic             err_sum_vld_r, seen_r, frame_start_s;
  logic [XW-1:0]    beat_sum_s, add_s;

  // Beat magnitude sum and saturating accumulate (restart on a new frame).
  always_comb begin
    beat_sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum_s = beat_sum_s + {{(XW-DATA_W){1'b0}}, abs_val(diff_s[i*DATA_W +: DATA_W])};
    end
    frame_start_s = data_out_fst && seen_r;
    if (frame_start_s) begin
      add_s = beat_sum_s;
    end else begin
      add_s = {{(XW-SUM_W){1'b0}}, acc_r} + beat_sum_s;
    end
    if (add_s > SUM_MAX) begin
      acc_nxt_s = {SUM_W{1'b1}};
    end else begin
      acc_nxt_s = add_s[SUM_W-1:0];
    end
  end

  // Frame total capture and one-cycle report pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r         <= '0;
      err_sum_r     <= '0;
      err_sum_vld_r <= 1'b0;
      seen_r        <= 1'b0;
    end else begin
      err_sum_vld_r <= 1'b0;
      if (join_s) begin
        seen_r <= 1'b1;
        acc_r  <= acc_nxt_s;
        if (frame_start_s) begin
          err_sum_r     <= acc_r;
          err_sum_vld_r <= 1'b1;
        end
      end
    end
  end

  assign err_sum     = err_sum_r;
  assign err_sum_vld = err_sum_vld_r;
`endif

endmodule
